// File: rtl/fp32_pkg.sv
// Shared FP32 field definitions, special constants and FSM states for the
// Babylonian square-root approximator.
package fp32_pkg;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int BIAS     = 127;
    localparam int DIV_BITS = 26;

    localparam logic [31:0] QNAN       = 32'h7FC0_0000;
    localparam logic [31:0] PINF       = 32'h7F80_0000;
    localparam logic [31:0] SEED_MAGIC = 32'h1FC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_DIV,
        ST_MEAN,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Pack a positive normal value and round to nearest even; a mantissa
    // carry ripples naturally into the exponent field.
    function automatic logic [31:0] fp_round_pack(
        input logic [EXP_W-1:0] exp,
        input logic [MAN_W-1:0] frac,
        input logic             guard,
        input logic             sticky
    );
        logic [31:0] word;
        word = {1'b0, exp, frac};
        if (guard && (sticky || frac[0])) begin
            word = word + 32'd1;
        end
        return word;
    endfunction

endpackage

// File: rtl/fp32_div_seq.sv
// Sequential restoring divider for positive normal FP32 operands.
// One quotient bit per cycle; o_done is high during the cycle that produces
// the last bit, with the rounded quotient on o_quo_fp in that same cycle.
module fp32_div_seq
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [30:0] i_a,
    input  logic [30:0] i_d,
    output logic        o_done,
    output logic [31:0] o_quo,
    output logic [31:0] o_quo_fp
);

    logic [25:0] r_rem;
    logic [24:0] r_q;
    logic [23:0] r_md;
    logic [7:0]  r_exp;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic [31:0] r_quo;

    logic        w_ge;
    logic [25:0] w_rem_sub;
    logic [25:0] w_rem_next;
    logic [25:0] w_q_next;
    logic        w_last;
    logic [7:0]  w_exp_start;
    logic [31:0] w_pack;

    assign w_ge        = r_rem >= {2'b00, r_md};
    assign w_rem_sub   = w_ge ? (r_rem - {2'b00, r_md}) : r_rem;
    assign w_rem_next  = {w_rem_sub[24:0], 1'b0};
    assign w_q_next    = {r_q, w_ge};
    assign w_last      = r_busy && (r_cnt == 5'd1);
    assign w_exp_start = i_a[30:23] - i_d[30:23] + 8'(BIAS);

    // Normalise the finished quotient (at most one left shift) and round.
    always_comb begin
        w_pack = '0;
        if (w_q_next[25]) begin
            w_pack = fp_round_pack(r_exp, w_q_next[24:2], w_q_next[1],
                                   w_q_next[0] | (w_rem_sub != 26'd0));
        end else begin
            w_pack = fp_round_pack(r_exp - 8'd1, w_q_next[23:1], w_q_next[0],
                                   w_rem_sub != 26'd0);
        end
    end

    // Load operands on start, then shift out one quotient bit per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem  <= '0;
            r_q    <= '0;
            r_md   <= '0;
            r_exp  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_quo  <= '0;
        end else if (i_start) begin
            r_rem  <= {3'b001, i_a[22:0]};
            r_md   <= {1'b1, i_d[22:0]};
            r_exp  <= w_exp_start;
            r_q    <= '0;
            r_cnt  <= 5'(DIV_BITS);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_rem <= w_rem_next;
            r_q   <= w_q_next[24:0];
            r_cnt <= r_cnt - 5'd1;
            r_quo <= w_last ? w_pack : {6'd0, w_q_next};
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_done   = w_last;
    assign o_quo    = r_quo;
    assign o_quo_fp = w_pack;

endmodule

// File: rtl/squareroot_f32_approx.sv
// Iterative FP32 square root by the Babylonian recurrence x' = (x + a/x)/2.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | one cycle after reset release, latches a
// ST_INIT  | classify a; specials finish at once, else seed den
// ST_DIV   | divider computes a/den, result latched on completion
// ST_MEAN  | 3-step adder: align, add, normalise/round -> mn
// ST_CHECK | converged or out of iterations -> DONE, else den <= mn
// ST_DONE  | rdy high, sqrt held until a changes or reset
module squareroot_f32_approx
    import fp32_pkg::*;
#(
    parameter int MAX_ITER = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    output logic        rdy,
    output logic [31:0] sqrt,
    output logic [31:0] den,
    output logic [31:0] divide_result,
    output logic [31:0] result,
    output logic [31:0] mn
);

    localparam int IW = $clog2(MAX_ITER + 1);

    state_t      r_state;
    logic [31:0] r_a;
    logic [31:0] r_den;
    logic [31:0] r_result;
    logic [31:0] r_mn;
    logic [31:0] r_sqrt;
    logic        r_rdy;
    logic [IW-1:0] r_iter;
    logic [1:0]  r_mstep;
    logic [25:0] r_al_big;
    logic [25:0] r_al_small;
    logic        r_al_stk;
    logic [7:0]  r_al_exp;
    logic [26:0] r_sum;
    logic        r_sum_stk;

    logic        w_a_chg;
    logic        w_special;
    logic [31:0] w_spec_val;
    logic [30:0] w_seed;
    logic        w_finish;
    logic        w_div_start;
    logic [30:0] w_div_d;
    logic        w_div_done;
    logic [31:0] w_div_live;
    logic [31:0] w_div_fp;
    logic [7:0]  w_exp_big;
    logic [7:0]  w_ediff;
    logic [23:0] w_m_big;
    logic [23:0] w_m_small;
    logic [49:0] w_shift_full;
    logic [25:0] w_al_small;
    logic        w_al_stk;
    logic [31:0] w_norm;
    logic [31:0] w_mean;

    assign w_a_chg     = (r_state != ST_IDLE) && (a != r_a);
    assign w_seed      = r_a[31:1] + SEED_MAGIC[30:0];
    assign w_finish    = (r_mn == r_den) || (r_iter == IW'(MAX_ITER));
    assign w_div_start = !w_a_chg && (((r_state == ST_INIT) && !w_special) ||
                                      ((r_state == ST_CHECK) && !w_finish));
    assign w_div_d     = (r_state == ST_INIT) ? w_seed : r_mn[30:0];

    fp32_div_seq u_div (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_div_start),
        .i_a      (r_a[30:0]),
        .i_d      (w_div_d),
        .o_done   (w_div_done),
        .o_quo    (w_div_live),
        .o_quo_fp (w_div_fp)
    );

    // Classify the latched operand; denormals are flushed to zero first.
    always_comb begin
        w_special  = 1'b1;
        w_spec_val = 32'd0;
        if (r_a[30:23] == 8'h00) begin
            w_spec_val = 32'd0;
        end else if ((r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'd0)) begin
            w_spec_val = QNAN;
        end else if (r_a[31]) begin
            w_spec_val = QNAN;
        end else if (r_a[30:23] == 8'hFF) begin
            w_spec_val = PINF;
        end else begin
            w_special = 1'b0;
        end
    end

    // Mean datapath: align den/result with sticky, then normalise and halve.
    always_comb begin
        if (r_den[30:23] >= r_result[30:23]) begin
            w_exp_big = r_den[30:23];
            w_ediff   = r_den[30:23] - r_result[30:23];
            w_m_big   = {1'b1, r_den[22:0]};
            w_m_small = {1'b1, r_result[22:0]};
        end else begin
            w_exp_big = r_result[30:23];
            w_ediff   = r_result[30:23] - r_den[30:23];
            w_m_big   = {1'b1, r_result[22:0]};
            w_m_small = {1'b1, r_den[22:0]};
        end
        w_shift_full = {w_m_small, 26'd0} >> w_ediff;
        if (w_ediff >= 8'd26) begin
            w_al_small = '0;
            w_al_stk   = 1'b1;
        end else begin
            w_al_small = w_shift_full[49:24];
            w_al_stk   = |w_shift_full[23:0];
        end
        if (r_sum[26]) begin
            w_norm = fp_round_pack(r_al_exp + 8'd1, r_sum[25:3], r_sum[2],
                                   (|r_sum[1:0]) | r_sum_stk);
        end else begin
            w_norm = fp_round_pack(r_al_exp, r_sum[24:2], r_sum[1],
                                   r_sum[0] | r_sum_stk);
        end
        w_mean = w_norm - 32'h0080_0000;
    end

    // Control FSM; any change of a restarts from INIT, whatever the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_a        <= '0;
            r_den      <= '0;
            r_result   <= '0;
            r_mn       <= '0;
            r_sqrt     <= '0;
            r_rdy      <= 1'b0;
            r_iter     <= '0;
            r_mstep    <= '0;
            r_al_big   <= '0;
            r_al_small <= '0;
            r_al_stk   <= 1'b0;
            r_al_exp   <= '0;
            r_sum      <= '0;
            r_sum_stk  <= 1'b0;
        end else if (w_a_chg) begin
            r_a     <= a;
            r_rdy   <= 1'b0;
            r_state <= ST_INIT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_a     <= a;
                    r_state <= ST_INIT;
                end
                ST_INIT: begin
                    r_iter <= IW'(1);
                    if (w_special) begin
                        r_sqrt  <= w_spec_val;
                        r_rdy   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_den   <= {1'b0, w_seed};
                        r_state <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (w_div_done) begin
                        r_result <= w_div_fp;
                        r_mstep  <= 2'd0;
                        r_state  <= ST_MEAN;
                    end
                end
                ST_MEAN: begin
                    r_mstep <= r_mstep + 2'd1;
                    case (r_mstep)
                        2'd0: begin
                            r_al_big   <= {w_m_big, 2'b00};
                            r_al_small <= w_al_small;
                            r_al_stk   <= w_al_stk;
                            r_al_exp   <= w_exp_big;
                        end
                        2'd1: begin
                            r_sum     <= {1'b0, r_al_big} + {1'b0, r_al_small};
                            r_sum_stk <= r_al_stk;
                        end
                        default: begin
                            r_mn    <= w_mean;
                            r_state <= ST_CHECK;
                        end
                    endcase
                end
                ST_CHECK: begin
                    if (w_finish) begin
                        r_sqrt  <= r_mn;
                        r_rdy   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_den   <= r_mn;
                        r_iter  <= r_iter + 1'b1;
                        r_state <= ST_DIV;
                    end
                end
                ST_DONE: begin
                    r_rdy <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rdy           = r_rdy;
    assign sqrt          = r_sqrt;
    assign den           = r_den;
    assign divide_result = w_div_live;
    assign result        = r_result;
    assign mn            = r_mn;

endmodule

// File: tb/tb_squareroot_f32_approx.sv
// Directed and random checks of the FP32 square-root approximator against a
// real-arithmetic reference.
module tb_squareroot_f32_approx;

    localparam int MAX_ITER = 6;
    localparam int LAT_MAX  = 2 + MAX_ITER * 30;
    localparam logic [31:0] QNAN_C = 32'h7FC0_0000;
    localparam logic [31:0] PINF_C = 32'h7F80_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a   = 32'h4000_0000;
    logic        rdy;
    logic [31:0] sqrt_o;
    logic [31:0] den;
    logic [31:0] divide_result;
    logic [31:0] result;
    logic [31:0] mn;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    squareroot_f32_approx #(.MAX_ITER(MAX_ITER)) dut (
        .clk           (clk),
        .rst           (rst),
        .a             (a),
        .rdy           (rdy),
        .sqrt          (sqrt_o),
        .den           (den),
        .divide_result (divide_result),
        .result        (result),
        .mn            (mn)
    );

    // Reference: specials by rule, otherwise double-precision sqrt rounded to FP32.
    function automatic logic [31:0] ref_sqrt(input logic [31:0] x);
        logic [63:0] db;
        logic [31:0] w;
        real         r;
        if (x[30:23] == 8'h00) return 32'h0;
        if ((x[30:23] == 8'hFF) && (x[22:0] != 23'd0)) return QNAN_C;
        if (x[31]) return QNAN_C;
        if (x[30:23] == 8'hFF) return PINF_C;
        db = {1'b0, ({3'b000, x[30:23]} + 11'd896), x[22:0], 29'd0};
        r  = $sqrt($bitstoreal(db));
        db = $realtobits(r);
        w  = {1'b0, 8'(db[62:52] - 11'd896), db[51:29]};
        if (db[28] && ((db[27:0] != 28'd0) || db[29])) w = w + 32'd1;
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ulp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        logic [31:0] diff;
        logic        ok;
        diff = (obs > exp) ? (obs - exp) : (exp - obs);
        ok   = (obs[31] === exp[31]) && (diff <= 32'd1);
        n_cmp++;
        assert (ok === 1'b1) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (+-1 ulp)", tag, obs, exp);
        end
    endtask

    task automatic wait_rdy(input int bound, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && (n < bound));
    endtask

    task automatic run_op(input string tag, input logic [31:0] val, input int bound, input bit exact);
        int n;
        a = val;
        wait_rdy(bound, n);
        check({tag, " rdy"}, {31'd0, rdy}, 32'd1);
        if (exact) check({tag, " sqrt"}, sqrt_o, ref_sqrt(val));
        else       check_ulp({tag, " sqrt"}, sqrt_o, ref_sqrt(val));
    endtask

    initial begin
        int          n;
        logic [31:0] v;
        logic [31:0] spec_in [4];

        spec_in[0] = 32'h0000_0000;
        spec_in[1] = 32'hC000_0000;
        spec_in[2] = 32'h7F80_0000;
        spec_in[3] = 32'h0000_0001;

        #1 rst = 1'b0;
        #3;
        check("reset rdy", {31'd0, rdy}, 32'd0);
        check("reset sqrt", sqrt_o, 32'd0);
        check("reset den", den, 32'd0);
        check("reset divide_result", divide_result, 32'd0);
        check("reset result", result, 32'd0);
        check("reset mn", mn, 32'd0);
        #5 rst = 1'b1;

        // 2.0 from reset release: seed check then convergence within bound
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("seed 2.0 den", den, 32'h3FC0_0000);
        wait_rdy(LAT_MAX - 2, n);
        check("2.0 rdy", {31'd0, rdy}, 32'd1);
        check_ulp("2.0 sqrt", sqrt_o, ref_sqrt(32'h4000_0000));

        // operand change while DONE
        a = 32'h4040_0000;
        @(posedge clk); #1;
        check("3.0 rdy drop", {31'd0, rdy}, 32'd0);
        wait_rdy(LAT_MAX - 1, n);
        check("3.0 rdy", {31'd0, rdy}, 32'd1);
        check_ulp("3.0 sqrt", sqrt_o, ref_sqrt(32'h4040_0000));

        // exact seeds converge after one iteration
        run_op("4.0", 32'h4080_0000, 32, 1'b1);
        check("4.0 den", den, 32'h4000_0000);
        run_op("0.25", 32'h3E80_0000, 32, 1'b1);

        for (int i = 0; i < 4; i++) begin
            run_op($sformatf("special%0d", i), spec_in[i], 3, 1'b1);
        end

        for (int i = 0; i < 12; i++) begin
            v = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
            run_op($sformatf("rand%0d %h", i, v), v, LAT_MAX, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            v = {1'b1, 8'($urandom_range(1, 254)), 23'($urandom)};
            run_op($sformatf("neg%0d %h", i, v), v, 3, 1'b1);
        end

        // reset in the middle of a divide
        a = 32'h4040_0000;
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst rdy", {31'd0, rdy}, 32'd0);
        check("midrst sqrt", sqrt_o, 32'd0);
        check("midrst den", den, 32'd0);
        check("midrst divide_result", divide_result, 32'd0);
        check("midrst result", result, 32'd0);
        check("midrst mn", mn, 32'd0);
        #3 rst = 1'b1;
        wait_rdy(LAT_MAX, n);
        check("post-reset rdy", {31'd0, rdy}, 32'd1);
        check_ulp("post-reset sqrt", sqrt_o, ref_sqrt(32'h4040_0000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
